pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 64, maximum data-memory wait cycles before an error is declared.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  synchronous, active-high; clock is clk.
REQ-004 Port: idex_memread  input  1  load instruction in EX stage.
REQ-005 Port: idex_rt  input  5  load destination register in EX.
REQ-006 Port: ifid_rs, ifid_rt  input  5 each  source registers of instruction in ID.
REQ-007 Port: exmem_memread, exmem_memwrite  input  1 each  memory access in MEM stage.
REQ-008 Port: dmem_ready  input  1  data memory completes the access this cycle.
REQ-009 Port: branch_taken  input  1  taken branch resolved in EX.
REQ-010 Port: dmem_req  output  1  data memory access request.
REQ-011 Port: pc_en, ifid_en, idex_en, exmem_en  output  1 each  stage register load enables.
REQ-012 Port: ifid_flush, idex_flush, memwb_flush  output  1 each  insert bubble (zero control bits) into that register.
REQ-013 Port: mem_timeout  output  1  sticky memory-timeout error.
REQ-014 Port: stall_cnt  output  16  count of cycles with pc_en=0.

Function
REQ-015 The FSM SHALL have states RUN, MEM_WAIT and ERR; state, the wait counter, mem_timeout and stall_cnt are registered; all other outputs are combinational from state and inputs.
REQ-016 dmem_req SHALL be 1 in RUN when exmem_memread|exmem_memwrite, 1 in MEM_WAIT, 0 in ERR.
REQ-017 mem_stall SHALL equal dmem_req & ~dmem_ready, or 1 in ERR.
REQ-018 RUN with dmem_req=1 and dmem_ready=1 SHALL be a zero-wait access: no stall, remain in RUN.
REQ-019 RUN with mem_stall=1 SHALL transition to MEM_WAIT and clear the wait counter to 1.
REQ-020 MEM_WAIT with dmem_ready=1 SHALL return to RUN; all enables 1 in that cycle.
REQ-021 MEM_WAIT with dmem_ready=0 SHALL increment the wait counter; when it reaches TIMEOUT the FSM enters ERR and sets mem_timeout.
REQ-022 ERR SHALL be left only by reset; mem_timeout stays 1 until reset.
REQ-023 While mem_stall=1: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush = 1; ifid_flush = idex_flush = 0; branch_taken and load-use ignored.
REQ-024 Load-use hazard = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
REQ-025 With no mem_stall and branch_taken=1: all enables 1, ifid_flush=1, idex_flush=1, load-use suppressed.
REQ-026 With no mem_stall, no branch, load-use=1: pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1, for exactly the cycles the hazard condition holds.
REQ-027 Otherwise all enables SHALL be 1 and all flushes 0.
REQ-028 stall_cnt SHALL increment on every cycle with pc_en=0 and saturate at 16'hFFFF.
REQ-029 Priority SHALL be: ERR > memory stall > branch flush > load-use > normal.

Reset
REQ-030 On reset: state RUN, wait counter 0, mem_timeout 0, stall_cnt 0; reset in any state, including MEM_WAIT and ERR, takes effect at the next edge.
REQ-031 While reset is high, outputs SHALL follow REQ-016..027 evaluated in RUN with the current inputs.

Verification
REQ-032 Load-use: idex_memread=1, idex_rt=8, ifid_rs=8, one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle, stall_cnt=1 after it.
REQ-033 $zero: idex_memread=1, idex_rt=0, ifid_rt=0 -> no stall, all enables 1.
REQ-034 Memory wait: exmem_memread=1, dmem_ready low 3 cycles then high -> dmem_req=1 for 4 cycles, enables 0 and memwb_flush=1 for 3 cycles, RUN afterwards, stall_cnt=3.
REQ-035 Branch + load-use same cycle, no mem access -> ifid_flush=idex_flush=1, pc_en=1.
REQ-036 Branch during mem stall -> no flush asserted; enables 0 until dmem_ready.
REQ-037 Timeout: TIMEOUT=4, exmem_memwrite=1, dmem_ready=0 -> mem_timeout=1 after 4 wait cycles, pipeline frozen; reset -> mem_timeout=0, state RUN, stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush control with data-memory wait and timeout FSM
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        exmem_memread,
  input  logic        exmem_memwrite,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_flush,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
  state_t state_q, state_d, cur;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic mem_stall, load_use;
  // Outputs decode the state as RUN while reset is held; priority ERR > mem stall > branch > load-use
  always_comb begin
    cur = reset ? RUN : state_q;
    dmem_req = (cur == MEM_WAIT) || (cur == RUN && (exmem_memread || exmem_memwrite));
    mem_stall = (cur == ERR) || (dmem_req && !dmem_ready);
    load_use = idex_memread && (idex_rt != 5'd0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
    pc_en = !mem_stall && (branch_taken || !load_use);
    ifid_en = pc_en;
    idex_en = !mem_stall;
    exmem_en = !mem_stall;
    ifid_flush = !mem_stall && branch_taken;
    idex_flush = !mem_stall && (branch_taken || load_use);
    memwb_flush = mem_stall;
  end
  // Next state, wait counter, sticky timeout and saturating stall counter
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d = (!pc_en && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    case (state_q)
      RUN: if (mem_stall) begin
        state_d = (TIMEOUT <= 1) ? ERR : MEM_WAIT;
        wcnt_d = CW'(1);
        mem_timeout_d = (TIMEOUT <= 1);
      end
      MEM_WAIT: if (dmem_ready) begin
        state_d = RUN;
        wcnt_d = '0;
      end else begin
        wcnt_d = wcnt_q + CW'(1);
        state_d = (wcnt_d == CW'(TIMEOUT)) ? ERR : MEM_WAIT;
        mem_timeout_d = (wcnt_d == CW'(TIMEOUT));
      end
      default: state_d = ERR;
    endcase
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wcnt_q <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with directed and random stimulus against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic idex_memread = 0, exmem_memread = 0, exmem_memwrite = 0, dmem_ready = 0, branch_taken = 0;
  logic [4:0] idex_rt = 0, ifid_rs = 0, ifid_rt = 0;
  logic dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, mem_timeout;
  logic [15:0] stall_cnt;
  typedef logic [24:0] vec_t;
  vec_t exp_q[$];
  int checks = 0, errors = 0;
  bit m_err = 0, m_wait = 0;
  int m_wcnt = 0, m_stall = 0;

  pipe_hazard_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .memwb_flush(memwb_flush), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation
  always @(negedge clk) begin
    vec_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, mem_timeout, stall_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got req/pc/ifid/idex/exmem/iff/idf/mwf/to=%b stall_cnt=%0d expected %b stall_cnt=%0d",
                 $time, a[24:16], a[15:0], e[24:16], e[15:0]);
      end
    end
  end

  // Apply one cycle of inputs, push the expected outputs, then advance the model across the edge
  task automatic drive(input bit r, input bit mr, input int irt, input int rs, input int rt,
                       input bit exr, input bit exw, input bit rdy, input bit br);
    bit err, wt, req, ms, lu, stop, mw, fl_if, fl_id;
    @(posedge clk);
    #1;
    reset = r; idex_memread = mr; idex_rt = 5'(irt); ifid_rs = 5'(rs); ifid_rt = 5'(rt);
    exmem_memread = exr; exmem_memwrite = exw; dmem_ready = rdy; branch_taken = br;
    err = !r && m_err;
    wt = !r && m_wait;
    req = err ? 0 : (wt ? 1 : (exr || exw));
    ms = err || (req && !rdy);
    lu = mr && irt != 0 && (irt == rs || irt == rt);
    stop = ms || (!br && lu);
    mw = ms;
    fl_if = !ms && br;
    fl_id = !ms && (br || lu);
    exp_q.push_back({req, !stop, !stop, !ms, !ms, fl_if, fl_id, mw, m_err, 16'(m_stall)});
    if (r) begin
      m_err = 0; m_wait = 0; m_wcnt = 0; m_stall = 0;
    end else begin
      if (stop && m_stall < 65535) m_stall++;
      if (m_err) ;
      else if (m_wait) begin
        if (rdy) m_wait = 0;
        else begin
          m_wcnt++;
          if (m_wcnt >= TO) begin m_err = 1; m_wait = 0; end
        end
      end else if (ms) begin
        m_wcnt = 1;
        if (TO <= 1) m_err = 1; else m_wait = 1;
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 8, 8, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use on rs, then its effect on stall_cnt
    drive(0, 1, 8, 8, 3, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // $zero destination never stalls
    drive(0, 1, 0, 5, 0, 0, 0, 0, 0);
    // memory wait of 3 cycles then ready
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // zero-wait access
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    // branch plus load-use in the same cycle
    drive(0, 1, 9, 1, 9, 0, 0, 0, 1);
    // branch during memory stall, then ready
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 1, 1);
    // timeout into ERR, frozen, then reset out of it
    for (int i = 0; i < 7; i++) drive(0, 1, 4, 4, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // reset while in MEM_WAIT
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
